tage_fold_history: RTL and testbench
====================================

# tage_fold_history

Speculative global-history generator for the TAGE predictor. It supplies the folded index and tag histories (`fold_idx`, `fold_tag1`, `fold_tag2`) that the TAGE banks consume at lookup. Each predicted block with a conditional branch updates these histories. Every prediction is checkpointed so that a backend redirect restores exact history. The block sits in the BPU next to the TAGE predictor and drives its history input.

## Interface
Parameters:
- `BANK_NUM`, default 4: number of tagged TAGE banks.
- `IDX_W`, default 8: folded index width (equals `TAGE_SET_WIDTH`).
- `TAG1_W`, default 12: width of folded tag history 1.
- `TAG2_W`, default 10: width of folded tag history 2.
- `HIST_LENS`, default 64'h0040_0020_0010_0008: 16-bit history length per bank; bank i is `[i*16 +: 16]`, so the defaults are 8, 16, 32, 64.
- `GHIST_SIZE`, default 128: circular global-history buffer depth. It must be at least max(`HIST_LENS`) + `CKPT_NUM`.
- `CKPT_NUM`, default 8: checkpoint entries. Must be a power of 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `stall`  in  1  BPU stall; blocks prediction updates only.
- `pred_valid`  in  1  a new predicted block is issued.
- `pred_cond`  in  1  the block contains a conditional branch, so one history bit is shifted in.
- `pred_taken`  in  1  predicted direction of that branch.
- `pred_ready`  out  1  a checkpoint is free.
- `pred_ckpt`  out  $clog2(CKPT_NUM)  checkpoint id assigned to the current prediction.
- `redirect_valid`  in  1  backend misprediction.
- `redirect_ckpt`  in  $clog2(CKPT_NUM)  checkpoint of the mispredicted block.
- `redirect_cond`  in  1  the corrected block contains a conditional branch.
- `redirect_taken`  in  1  corrected direction.
- `commit_valid`  in  1  retires the oldest checkpoint.
- `fold_idx`  out  BANK_NUM×IDX_W  folded index history per bank.
- `fold_tag1`  out  BANK_NUM×TAG1_W  folded tag history 1 per bank.
- `fold_tag2`  out  BANK_NUM×TAG2_W  folded tag history 2 per bank.

## Operation
- **State.**
  - `ghist[GHIST_SIZE]` is a circular buffer; `ptr` is the index of the newest bit.
  - The fold registers (`fold_idx`, `fold_tag1`, `fold_tag2`) hold the folded histories.
  - The checkpoint FIFO has `head`/`tail` plus a count. Each entry stores {`ptr`, all folds}.
- **Fold invariant.** For a fold of width W over length L: fold = XOR over j<L of ghist[ptr−j] << (j mod W).
- **Shift with bit b.** For each fold: fold' = rotl1(fold) ^ b ^ (ghist[ptr−L+1] << (L mod W)). Then `ptr'` = ptr+1 (mod GHIST_SIZE) and ghist[ptr'] = b.
- **Prediction accept** (`pred_valid & pred_ready & ~stall & ~redirect_valid`):
  - Write the current state into checkpoint[`tail`].
  - `pred_ckpt` = `tail`; increment `tail`.
  - If `pred_cond`, shift with `pred_taken`; otherwise the histories are unchanged.
- **Redirect** (`redirect_valid`):
  - Load `ptr` and the folds from checkpoint[`redirect_ckpt`].
  - If `redirect_cond`, apply a shift with `redirect_taken` to the restored state in the same cycle.
  - `tail` = `redirect_ckpt`+1 (mod CKPT_NUM). Younger checkpoints are discarded; the count is recomputed as tail−head.
- **Commit.** `commit_valid` advances `head`. Committing with count 0 is ignored.
- **`pred_ready`** = count < CKPT_NUM.
- **Simultaneous events.**
  - Redirect has priority over prediction; the prediction is dropped.
  - Commit together with prediction leaves the count unchanged.
  - Commit together with redirect: head advances first, then tail is set from `redirect_ckpt`.

## Timing
- All outputs are registered.
- Fold changes caused by an accepted prediction or a redirect are visible on the cycle after the edge.
- `pred_ckpt` is combinational from `tail` and valid in the same cycle as `pred_valid`.
- `stall` freezes prediction updates only; redirect and commit still act.
- Reset, including reset asserted mid-operation, takes one edge and sets:
  - all folds, `ghist`, `ptr`, `head`, `tail` and count to 0;
  - `pred_ready` to 1 and `pred_ckpt` to 0.
- All pointer arithmetic wraps modulo its depth. There is no full/empty ambiguity because an explicit count is kept.

## Configuration
- **`TAGE_FOLD_CHECK_EN` defined:** a simulation-only checker recomputes every fold directly from `ghist` each cycle and raises `$error` on any mismatch with the fold registers.
- **Not defined:** the checker is absent and the RTL is otherwise identical.

## Test plan
- **Reset:** pulse `rst` mid-stream → all folds read 0, `pred_ready`=1, `pred_ckpt`=0 on the next cycle.
- **Short history:** 8 predictions with cond=1, taken=1 (bank0 L=8, IDX_W=8) → `fold_idx[0]`=8'hFF. A 9th taken prediction leaves it at 8'hFF because the oldest bit is cancelled.
- **No conditional branch:** a prediction with `pred_cond`=0 → folds unchanged and `pred_ckpt` increments by 1.
- **Full queue:** 8 accepted predictions with no commit → `pred_ready`=0 and a 9th `pred_valid` is ignored. One commit → `pred_ready`=1 the next cycle.
- **Redirect:**
  - Predict taken at ckpt 2, then 3 more predictions; redirect `redirect_ckpt`=2 with not-taken.
  - Required: folds equal the values obtained from a reference history with not-taken at that position, `tail`=3, and the next `pred_ckpt`=3.
- **Simultaneous events:**
  - Redirect and `pred_valid` in the same cycle → the prediction is dropped.
  - Commit and `pred_valid` in the same cycle at count 8 → `pred_ready` was 0, so the prediction is not accepted, and the count becomes 7.

Source files
------------

// File: rtl/tage_fold_history_if.sv
// Handshake bundle between the BPU front end and the TAGE folded-history generator.
interface tage_fold_history_if #(
  parameter int BANK_NUM = 4,
  parameter int IDX_W    = 8,
  parameter int TAG1_W   = 12,
  parameter int TAG2_W   = 10,
  parameter int CKPT_NUM = 8
);
  localparam int CKPT_W = $clog2(CKPT_NUM);

  logic                       stall;
  logic                       pred_valid;
  logic                       pred_cond;
  logic                       pred_taken;
  logic                       pred_ready;
  logic [CKPT_W-1:0]          pred_ckpt;
  logic                       redirect_valid;
  logic [CKPT_W-1:0]          redirect_ckpt;
  logic                       redirect_cond;
  logic                       redirect_taken;
  logic                       commit_valid;
  logic [BANK_NUM*IDX_W-1:0]  fold_idx;
  logic [BANK_NUM*TAG1_W-1:0] fold_tag1;
  logic [BANK_NUM*TAG2_W-1:0] fold_tag2;

  modport master (
    output stall, pred_valid, pred_cond, pred_taken,
    output redirect_valid, redirect_ckpt, redirect_cond, redirect_taken, commit_valid,
    input  pred_ready, pred_ckpt, fold_idx, fold_tag1, fold_tag2
  );

  modport slave (
    input  stall, pred_valid, pred_cond, pred_taken,
    input  redirect_valid, redirect_ckpt, redirect_cond, redirect_taken, commit_valid,
    output pred_ready, pred_ckpt, fold_idx, fold_tag1, fold_tag2
  );
endinterface

// File: rtl/tage_fold_history.sv
// Speculative folded global history for TAGE with per-prediction checkpoints and redirect restore.
// Define TAGE_FOLD_CHECK_EN to build in a simulation-only checker that recomputes folds from ghist.
module tage_fold_history #(
  parameter int                     BANK_NUM   = 4,
  parameter int                     IDX_W      = 8,
  parameter int                     TAG1_W     = 12,
  parameter int                     TAG2_W     = 10,
  parameter logic [16*BANK_NUM-1:0] HIST_LENS  = 64'h0040_0020_0010_0008,
  parameter int                     GHIST_SIZE = 128,
  parameter int                     CKPT_NUM   = 8
) (
  input logic                clk,
  input logic                rst,
  tage_fold_history_if.slave bus
);
  localparam int                CKPT_W    = $clog2(CKPT_NUM);
  localparam int                PTR_W     = $clog2(GHIST_SIZE);
  localparam logic [CKPT_W:0]   CKPT_FULL = (CKPT_W+1)'(CKPT_NUM);

  function automatic int hist_len(input int bank);
    return int'(HIST_LENS[bank*16 +: 16]);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_back(input logic [PTR_W-1:0] p, input int back);
    int t;
    t = int'(p) - back;
    return PTR_W'((t < 0) ? t + GHIST_SIZE : t);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_fwd(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(GHIST_SIZE - 1)) ? '0 : p + PTR_W'(1'b1);
  endfunction

  logic [GHIST_SIZE-1:0]             ghist_r;
  logic [PTR_W-1:0]                  ptr_r;
  logic [BANK_NUM-1:0][IDX_W-1:0]    idx_r;
  logic [BANK_NUM-1:0][TAG1_W-1:0]   tag1_r;
  logic [BANK_NUM-1:0][TAG2_W-1:0]   tag2_r;
  logic [CKPT_W-1:0]                 head_r;
  logic [CKPT_W-1:0]                 tail_r;
  logic [CKPT_W:0]                   count_r;
  logic                              ready_r;

  logic [PTR_W-1:0]                  ck_ptr_r  [CKPT_NUM];
  logic [BANK_NUM-1:0][IDX_W-1:0]    ck_idx_r  [CKPT_NUM];
  logic [BANK_NUM-1:0][TAG1_W-1:0]   ck_tag1_r [CKPT_NUM];
  logic [BANK_NUM-1:0][TAG2_W-1:0]   ck_tag2_r [CKPT_NUM];

  logic                              accept_s;
  logic                              commit_s;
  logic                              shift_s;
  logic                              bit_s;
  logic [PTR_W-1:0]                  base_ptr_s;
  logic [PTR_W-1:0]                  nptr_s;
  logic [PTR_W-1:0]                  ptr_nxt_s;
  logic [BANK_NUM-1:0][IDX_W-1:0]    base_idx_s,  sh_idx_s,  idx_nxt_s;
  logic [BANK_NUM-1:0][TAG1_W-1:0]   base_tag1_s, sh_tag1_s, tag1_nxt_s;
  logic [BANK_NUM-1:0][TAG2_W-1:0]   base_tag2_s, sh_tag2_s, tag2_nxt_s;
  logic [BANK_NUM-1:0]               out_s;
  logic [CKPT_W-1:0]                 head_nxt_s;
  logic [CKPT_W-1:0]                 tail_nxt_s;
  logic [CKPT_W-1:0]                 diff_s;
  logic [CKPT_W:0]                   count_nxt_s;
  logic                              ready_nxt_s;

  // Select base state (live or restored checkpoint), apply optional shift, update queue pointers.
  always_comb begin
    accept_s = bus.pred_valid & ready_r & ~bus.stall & ~bus.redirect_valid;
    commit_s = bus.commit_valid & (count_r != '0);
    if (bus.redirect_valid) begin
      base_ptr_s  = ck_ptr_r[bus.redirect_ckpt];
      base_idx_s  = ck_idx_r[bus.redirect_ckpt];
      base_tag1_s = ck_tag1_r[bus.redirect_ckpt];
      base_tag2_s = ck_tag2_r[bus.redirect_ckpt];
      shift_s     = bus.redirect_cond;
      bit_s       = bus.redirect_taken;
    end else begin
      base_ptr_s  = ptr_r;
      base_idx_s  = idx_r;
      base_tag1_s = tag1_r;
      base_tag2_s = tag2_r;
      shift_s     = accept_s & bus.pred_cond;
      bit_s       = bus.pred_taken;
    end

    nptr_s = ptr_fwd(base_ptr_s);
    // The bit leaving each window sits at ptr-L+1 and lands at position L mod W after rotation.
    for (int b = 0; b < BANK_NUM; b++) begin
      out_s[b]     = ghist_r[ptr_back(base_ptr_s, hist_len(b) - 1)];
      sh_idx_s[b]  = {base_idx_s[b][IDX_W-2:0], base_idx_s[b][IDX_W-1]} ^ IDX_W'(bit_s)
                   ^ (IDX_W'(out_s[b]) << (hist_len(b) % IDX_W));
      sh_tag1_s[b] = {base_tag1_s[b][TAG1_W-2:0], base_tag1_s[b][TAG1_W-1]} ^ TAG1_W'(bit_s)
                   ^ (TAG1_W'(out_s[b]) << (hist_len(b) % TAG1_W));
      sh_tag2_s[b] = {base_tag2_s[b][TAG2_W-2:0], base_tag2_s[b][TAG2_W-1]} ^ TAG2_W'(bit_s)
                   ^ (TAG2_W'(out_s[b]) << (hist_len(b) % TAG2_W));
    end
    ptr_nxt_s  = shift_s ? nptr_s    : base_ptr_s;
    idx_nxt_s  = shift_s ? sh_idx_s  : base_idx_s;
    tag1_nxt_s = shift_s ? sh_tag1_s : base_tag1_s;
    tag2_nxt_s = shift_s ? sh_tag2_s : base_tag2_s;

    head_nxt_s = head_r + CKPT_W'(commit_s);
    diff_s     = bus.redirect_ckpt - head_r;
    if (bus.redirect_valid) begin
      tail_nxt_s  = bus.redirect_ckpt + CKPT_W'(1'b1);
      count_nxt_s = {1'b0, diff_s} + (CKPT_W+1)'(1'b1) - (CKPT_W+1)'(commit_s);
    end else begin
      tail_nxt_s  = tail_r + CKPT_W'(accept_s);
      count_nxt_s = count_r + (CKPT_W+1)'(accept_s) - (CKPT_W+1)'(commit_s);
    end
    ready_nxt_s = (count_nxt_s < CKPT_FULL);
  end

  // State, history buffer and checkpoint storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghist_r <= '0;
      ptr_r   <= '0;
      idx_r   <= '0;
      tag1_r  <= '0;
      tag2_r  <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      ready_r <= 1'b1;
      for (int k = 0; k < CKPT_NUM; k++) begin
        ck_ptr_r[k]  <= '0;
        ck_idx_r[k]  <= '0;
        ck_tag1_r[k] <= '0;
        ck_tag2_r[k] <= '0;
      end
    end else begin
      ptr_r   <= ptr_nxt_s;
      idx_r   <= idx_nxt_s;
      tag1_r  <= tag1_nxt_s;
      tag2_r  <= tag2_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
      ready_r <= ready_nxt_s;
      if (shift_s) begin
        ghist_r[nptr_s] <= bit_s;
      end
      if (accept_s) begin
        ck_ptr_r[tail_r]  <= ptr_r;
        ck_idx_r[tail_r]  <= idx_r;
        ck_tag1_r[tail_r] <= tag1_r;
        ck_tag2_r[tail_r] <= tag2_r;
      end
    end
  end

  assign bus.pred_ready = ready_r;
  assign bus.pred_ckpt  = tail_r;
  assign bus.fold_idx   = idx_r;
  assign bus.fold_tag1  = tag1_r;
  assign bus.fold_tag2  = tag2_r;

`ifdef TAGE_FOLD_CHECK_EN
  // Recompute every fold from the raw history and flag drift in the incremental update.
  always @(negedge clk) begin : fold_check
    logic [IDX_W-1:0]  ref_idx;
    logic [TAG1_W-1:0] ref_tag1;
    logic [TAG2_W-1:0] ref_tag2;
    logic              hbit;
    if (rst == 1'b0) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        ref_idx  = '0;
        ref_tag1 = '0;
        ref_tag2 = '0;
        for (int j = 0; j < hist_len(b); j++) begin
          hbit = ghist_r[ptr_back(ptr_r, j)];
          ref_idx[j % IDX_W]   = ref_idx[j % IDX_W] ^ hbit;
          ref_tag1[j % TAG1_W] = ref_tag1[j % TAG1_W] ^ hbit;
          ref_tag2[j % TAG2_W] = ref_tag2[j % TAG2_W] ^ hbit;
        end
        if ((ref_idx !== idx_r[b]) || (ref_tag1 !== tag1_r[b]) || (ref_tag2 !== tag2_r[b])) begin
          $error("fold drift in bank %0d", b);
        end
      end
    end
  end
`else
  // Default build carries no self-check logic.
`endif

endmodule

// File: tb/tb_tage_fold_history.sv
// Directed bench for tage_fold_history: folds are compared against a newest-first history queue.
module tb_tage_fold_history;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tage_fold_history_if bus ();
  tage_fold_history dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  bit hq[$];
  int ck_len[8];
  int exp_cnt, exp_tail, exp_head;
  int lens[4] = '{8, 16, 32, 64};

  // Folds straight from the definition: XOR of hist[j] at bit j mod W for j < L.
  function automatic logic [119:0] ref_folds();
    logic [31:0] fi;
    logic [47:0] f1;
    logic [39:0] f2;
    fi = '0; f1 = '0; f2 = '0;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < lens[b] && j < hq.size(); j++) begin
        if (hq[j]) begin
          fi[b*8 + j%8]   ^= 1'b1;
          f1[b*12 + j%12] ^= 1'b1;
          f2[b*10 + j%10] ^= 1'b1;
        end
      end
    end
    return {fi, f1, f2};
  endfunction

  function automatic logic [119:0] dut_folds();
    return {bus.fold_idx, bus.fold_tag1, bus.fold_tag2};
  endfunction

  task automatic clear_inputs();
    bus.stall = 1'b0; bus.pred_valid = 1'b0; bus.pred_cond = 1'b0; bus.pred_taken = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_ckpt = 3'd0; bus.redirect_cond = 1'b0;
    bus.redirect_taken = 1'b0; bus.commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    hq.delete();
    exp_cnt = 0; exp_tail = 0; exp_head = 0;
  endtask

  task automatic drive(input bit pv, pc, pt, rv, input int rck, input bit rc, rt, cv, st);
    bit acc, cm;
    bus.pred_valid = pv; bus.pred_cond = pc; bus.pred_taken = pt;
    bus.redirect_valid = rv; bus.redirect_ckpt = 3'(rck); bus.redirect_cond = rc;
    bus.redirect_taken = rt; bus.commit_valid = cv; bus.stall = st;
    acc = pv && (exp_cnt < 8) && !st && !rv;
    cm  = cv && (exp_cnt > 0);
    @(posedge clk); #1;
    clear_inputs();
    if (rv) begin
      while (hq.size() > ck_len[rck]) void'(hq.pop_front());
      if (rc) hq.push_front(rt);
      exp_tail = (rck + 1) % 8;
      exp_cnt  = ((rck - exp_head + 8) % 8) + 1 - int'(cm);
    end else begin
      if (acc) begin
        ck_len[exp_tail] = hq.size();
        if (pc) hq.push_front(pt);
        exp_tail = (exp_tail + 1) % 8;
      end
      exp_cnt = exp_cnt + int'(acc) - int'(cm);
    end
    exp_head = (exp_head + int'(cm)) % 8;
  endtask

  task automatic pred(input bit c, input bit t);
    drive(1'b1, c, t, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic commit();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (dut_folds() !== 120'd0) $display("FAIL reset_folds got %h want 0", dut_folds()); else n_pass++;
    n_total++; if (bus.pred_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.pred_ready); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd0) $display("FAIL reset_ckpt got %0d want 0", bus.pred_ckpt); else n_pass++;
    pred(1'b1, 1'b1); pred(1'b1, 1'b0); pred(1'b1, 1'b1); commit();
    bus.pred_valid = 1'b1; bus.pred_cond = 1'b1; bus.pred_taken = 1'b1;
    do_reset();
    n_total++; if (dut_folds() !== 120'd0) $display("FAIL midreset_folds got %h want 0", dut_folds()); else n_pass++;
    n_total++; if (bus.pred_ready !== 1'b1) $display("FAIL midreset_ready got %b want 1", bus.pred_ready); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd0) $display("FAIL midreset_ckpt got %0d want 0", bus.pred_ckpt); else n_pass++;
  endtask

  task automatic test_short_history();
    do_reset();
    for (int i = 0; i < 8; i++) pred(1'b1, 1'b1);
    n_total++; if (bus.fold_idx[7:0] !== 8'hFF) $display("FAIL short_idx0_8 got %h want ff", bus.fold_idx[7:0]); else n_pass++;
    commit();
    pred(1'b1, 1'b1);
    n_total++; if (bus.fold_idx[7:0] !== 8'hFF) $display("FAIL short_idx0_9 got %h want ff", bus.fold_idx[7:0]); else n_pass++;
    n_total++; if (dut_folds() !== ref_folds()) $display("FAIL short_all got %h want %h", dut_folds(), ref_folds()); else n_pass++;
  endtask

  task automatic test_no_cond();
    logic [119:0] saved;
    do_reset();
    pred(1'b1, 1'b1); pred(1'b1, 1'b0);
    saved = ref_folds();
    pred(1'b0, 1'b1);
    n_total++; if (dut_folds() !== saved) $display("FAIL nocond_folds got %h want %h", dut_folds(), saved); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd3) $display("FAIL nocond_ckpt got %0d want 3", bus.pred_ckpt); else n_pass++;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_total++; if (dut_folds() !== saved) $display("FAIL stall_folds got %h want %h", dut_folds(), saved); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd3) $display("FAIL stall_ckpt got %0d want 3", bus.pred_ckpt); else n_pass++;
  endtask

  task automatic test_full_queue();
    logic [119:0] saved;
    do_reset();
    commit();
    for (int i = 0; i < 8; i++) pred(1'b1, (i % 3) == 0);
    n_total++; if (bus.pred_ready !== 1'b0) $display("FAIL full_ready got %b want 0", bus.pred_ready); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd0) $display("FAIL full_ckpt got %0d want 0", bus.pred_ckpt); else n_pass++;
    saved = dut_folds();
    n_total++; if (saved !== ref_folds()) $display("FAIL full_folds got %h want %h", saved, ref_folds()); else n_pass++;
    pred(1'b1, 1'b1);
    n_total++; if (dut_folds() !== saved) $display("FAIL full_drop_folds got %h want %h", dut_folds(), saved); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd0) $display("FAIL full_drop_ckpt got %0d want 0", bus.pred_ckpt); else n_pass++;
    commit();
    n_total++; if (bus.pred_ready !== 1'b1) $display("FAIL full_commit_ready got %b want 1", bus.pred_ready); else n_pass++;
    pred(1'b1, 1'b0);
    n_total++; if (bus.pred_ready !== 1'b0) $display("FAIL full_refill_ready got %b want 0", bus.pred_ready); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd1) $display("FAIL full_refill_ckpt got %0d want 1", bus.pred_ckpt); else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    pred(1'b1, 1'b1); pred(1'b1, 1'b0);
    n_total++; if (bus.pred_ckpt !== 3'd2) $display("FAIL redir_pre_ckpt got %0d want 2", bus.pred_ckpt); else n_pass++;
    pred(1'b1, 1'b1); pred(1'b1, 1'b1); pred(1'b1, 1'b0); pred(1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.fold_idx !== 32'h04040404) $display("FAIL redir_idx got %h want 04040404", bus.fold_idx); else n_pass++;
    n_total++; if (dut_folds() !== ref_folds()) $display("FAIL redir_folds got %h want %h", dut_folds(), ref_folds()); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd3) $display("FAIL redir_ckpt got %0d want 3", bus.pred_ckpt); else n_pass++;
    n_total++; if (bus.pred_ready !== 1'b1) $display("FAIL redir_ready got %b want 1", bus.pred_ready); else n_pass++;
    pred(1'b1, 1'b1);
    n_total++; if (bus.pred_ckpt !== 3'd4) $display("FAIL redir_next_ckpt got %0d want 4", bus.pred_ckpt); else n_pass++;
    n_total++; if (dut_folds() !== ref_folds()) $display("FAIL redir_next_folds got %h want %h", dut_folds(), ref_folds()); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [119:0] saved;
    do_reset();
    pred(1'b1, 1'b1); pred(1'b1, 1'b1); pred(1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.fold_idx !== 32'h02020202) $display("FAIL sim_redir_pred_idx got %h want 02020202", bus.fold_idx); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd2) $display("FAIL sim_redir_pred_ckpt got %0d want 2", bus.pred_ckpt); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++; if (bus.fold_idx !== 32'h01010101) $display("FAIL sim_redir_commit_idx got %h want 01010101", bus.fold_idx); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd2) $display("FAIL sim_redir_commit_ckpt got %0d want 2", bus.pred_ckpt); else n_pass++;
    for (int i = 0; i < 6; i++) pred(1'b1, i[0]);
    n_total++; if (bus.pred_ready !== 1'b1) $display("FAIL sim_count7_ready got %b want 1", bus.pred_ready); else n_pass++;
    pred(1'b1, 1'b1);
    n_total++; if (bus.pred_ready !== 1'b0) $display("FAIL sim_count8_ready got %b want 0", bus.pred_ready); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd1) $display("FAIL sim_count8_ckpt got %0d want 1", bus.pred_ckpt); else n_pass++;
    n_total++; if (dut_folds() !== ref_folds()) $display("FAIL sim_count8_folds got %h want %h", dut_folds(), ref_folds()); else n_pass++;
    do_reset();
    for (int i = 0; i < 8; i++) pred(1'b1, (i % 2) == 0);
    saved = dut_folds();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++; if (dut_folds() !== saved) $display("FAIL sim_full_commit_folds got %h want %h", dut_folds(), saved); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd0) $display("FAIL sim_full_commit_ckpt got %0d want 0", bus.pred_ckpt); else n_pass++;
    n_total++; if (bus.pred_ready !== 1'b1) $display("FAIL sim_full_commit_ready got %b want 1", bus.pred_ready); else n_pass++;
    pred(1'b1, 1'b1);
    n_total++; if (bus.pred_ready !== 1'b0) $display("FAIL sim_refill_ready got %b want 0", bus.pred_ready); else n_pass++;
    n_total++; if (bus.pred_ckpt !== 3'd1) $display("FAIL sim_refill_ckpt got %0d want 1", bus.pred_ckpt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] pat;
    do_reset();
    pat = 64'hC3A5_0F96_7E18_D24B;
    for (int i = 0; i < 80; i++) begin
      drive(1'b1, (i % 5) != 4, pat[i % 64] ^ (i >= 64), 1'b0, 0, 1'b0, 1'b0, i > 0, 1'b0);
      n_total++;
      if (dut_folds() !== ref_folds()) $display("FAIL b2b_folds step %0d got %h want %h", i, dut_folds(), ref_folds());
      else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, (exp_tail + 7) % 8, 1'b1, 1'b1, 1'b0, 1'b0);
    n_total++; if (dut_folds() !== ref_folds()) $display("FAIL b2b_redir_folds got %h want %h", dut_folds(), ref_folds()); else n_pass++;
    pred(1'b1, 1'b0);
    n_total++; if (dut_folds() !== ref_folds()) $display("FAIL b2b_after_folds got %h want %h", dut_folds(), ref_folds()); else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_short_history();
    test_no_cond();
    test_full_queue();
    test_redirect();
    test_simultaneous();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
